// File: rtl/bulls_and_cows_solver.sv
// ---------------------------------------------------------------------------
// bulls_and_cows_solver
//
// Automatic guessing player for Bulls and Cows (4 digits, each 0..7).
// Phase 1 presents dddd for each digit d to learn how often d occurs in the
// secret. Phase 2 locates each position by presenting one candidate digit
// against a filler digit that is known to be absent from the secret.
//
// Optional feature macro: SOLVER_EARLY_EXIT_EN
//   defined   : the scan stops as soon as the bull sum reaches 4; a sum
//               above 4 at any capture is flagged as an error.
//   undefined : all eight scan guesses are issued and the sum is checked
//               once, at the end of the scan.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   start                   begin a solve (accepted in IDLE or DONE only)
//   resp_in[7:0]            packed score: bulls = {[6:5],[1:0]},
//                           cows = {[7],[4:2]}
//   resp_valid              resp_in belongs to the guess on display
//   guess_A..guess_D[2:0]   current guess digits
//   guess_valid             guess is stable and a response is awaited
//   busy                    solve in progress
//   solved, error           outcome flags, held until the next start
//   found_A..found_D[2:0]   recovered secret digits (valid with solved)
//   guess_count[4:0]        responses consumed in this solve (saturating)
// ---------------------------------------------------------------------------
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | after reset, waiting for start
//  SCAN_GUESS | load dddd for the current scan digit (1 cycle)
//  SCAN_WAIT  | guess_valid high, waiting for the scan response
//  PICK_FILL  | choose filler digit and first candidate (1 cycle)
//  POS_GUESS  | load candidate-at-position, filler elsewhere (1 cycle)
//  POS_WAIT   | guess_valid high, waiting for the position response
//  DONE       | solved or error reported, waiting for start
// ---------------------------------------------------------------------------
module bulls_and_cows_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] resp_in,
    input  logic       resp_valid,
    output logic [2:0] guess_A,
    output logic [2:0] guess_B,
    output logic [2:0] guess_C,
    output logic [2:0] guess_D,
    output logic       guess_valid,
    output logic       busy,
    output logic       solved,
    output logic       error,
    output logic [2:0] found_A,
    output logic [2:0] found_B,
    output logic [2:0] found_C,
    output logic [2:0] found_D,
    output logic [4:0] guess_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SCAN_GUESS = 3'd1,
        SCAN_WAIT  = 3'd2,
        PICK_FILL  = 3'd3,
        POS_GUESS  = 3'd4,
        POS_WAIT   = 3'd5,
        DONE       = 3'd6
    } state_t;

    state_t     state, state_nxt;

    logic [2:0] count [8];
    logic [2:0] sum;
    logic [2:0] digit;
    logic [2:0] filler;
    logic [2:0] cand;
    logic [1:0] pos;
    logic [2:0] guess_q [4];
    logic [2:0] found_q [4];

    // Response decode. Cows are decoded for completeness but not used.
    logic [3:0] bulls;
    logic [3:0] cows;
    logic       unused_cows;
    logic [2:0] bulls_sat;
    logic [3:0] sum_nxt;

    assign bulls       = {resp_in[6:5], resp_in[1:0]};
    assign cows        = {resp_in[7], resp_in[4:2]};
    assign unused_cows = ^cows;
    assign bulls_sat   = (bulls > 4'd4) ? 3'd4 : bulls[2:0];
    assign sum_nxt     = {1'b0, sum} + {1'b0, bulls_sat};

    // Scan outcome for the response currently on resp_in.
    logic scan_pass;
    logic scan_fail;

`ifdef SOLVER_EARLY_EXIT_EN
    assign scan_pass = (sum_nxt == 4'd4);
    assign scan_fail = (sum_nxt > 4'd4) || ((digit == 3'd7) && (sum_nxt != 4'd4));
`else
    // The running sum is only 3 bits wide, so it is compared modulo 8.
    assign scan_pass = (digit == 3'd7) && (sum_nxt[2:0] == 3'd4);
    assign scan_fail = (digit == 3'd7) && (sum_nxt[2:0] != 3'd4);
`endif

    logic pos_hit;
    logic pos_miss;

    assign pos_hit  = (bulls == 4'd1);
    assign pos_miss = (bulls == 4'd0);

    // Lowest digit with a zero count. Unscanned digits keep count 0, so in
    // the early-exit build this naturally falls back to the first unscanned
    // digit when every scanned digit occurred in the secret.
    logic [2:0] fill_digit;

    always_comb begin
        fill_digit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (count[i] == 3'd0) fill_digit = 3'(i);
        end
    end

    // First candidate overall, and next candidate above the current one.
    logic       has_first;
    logic [2:0] first_cand;
    logic       has_next;
    logic [2:0] next_cand;

    always_comb begin
        has_first  = 1'b0;
        first_cand = 3'd0;
        has_next   = 1'b0;
        next_cand  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (count[i] != 3'd0) begin
                has_first  = 1'b1;
                first_cand = 3'(i);
                if (3'(i) > cand) begin
                    has_next  = 1'b1;
                    next_cand = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = SCAN_GUESS;
            end
            SCAN_GUESS: state_nxt = SCAN_WAIT;
            SCAN_WAIT: begin
                if (resp_valid) begin
                    if (scan_pass)      state_nxt = PICK_FILL;
                    else if (scan_fail) state_nxt = DONE;
                    else                state_nxt = SCAN_GUESS;
                end
            end
            PICK_FILL: state_nxt = has_first ? POS_GUESS : DONE;
            POS_GUESS: state_nxt = POS_WAIT;
            POS_WAIT: begin
                if (resp_valid) begin
                    if (pos_hit)                   state_nxt = (pos == 2'd3) ? DONE : POS_GUESS;
                    else if (pos_miss && has_next) state_nxt = POS_GUESS;
                    else                           state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) count[i] <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                guess_q[i] <= 3'd0;
                found_q[i] <= 3'd0;
            end
            sum         <= 3'd0;
            digit       <= 3'd0;
            filler      <= 3'd0;
            cand        <= 3'd0;
            pos         <= 2'd0;
            solved      <= 1'b0;
            error       <= 1'b0;
            guess_count <= 5'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int i = 0; i < 8; i++) count[i] <= 3'd0;
                        for (int i = 0; i < 4; i++) begin
                            guess_q[i] <= 3'd0;
                            found_q[i] <= 3'd0;
                        end
                        sum         <= 3'd0;
                        digit       <= 3'd0;
                        solved      <= 1'b0;
                        error       <= 1'b0;
                        guess_count <= 5'd0;
                    end
                end
                SCAN_GUESS: begin
                    for (int i = 0; i < 4; i++) guess_q[i] <= digit;
                end
                SCAN_WAIT: begin
                    if (resp_valid) begin
                        count[digit] <= bulls_sat;
                        sum          <= sum_nxt[2:0];
                        digit        <= digit + 3'd1;
                        if (guess_count != 5'd31) guess_count <= guess_count + 5'd1;
                        if (scan_fail) error <= 1'b1;
                    end
                end
                PICK_FILL: begin
                    filler <= fill_digit;
                    cand   <= first_cand;
                    pos    <= 2'd0;
                    if (!has_first) error <= 1'b1;
                end
                POS_GUESS: begin
                    for (int i = 0; i < 4; i++) begin
                        guess_q[i] <= (pos == 2'(i)) ? cand : filler;
                    end
                end
                POS_WAIT: begin
                    if (resp_valid) begin
                        if (guess_count != 5'd31) guess_count <= guess_count + 5'd1;
                        if (pos_hit) begin
                            found_q[pos] <= cand;
                            cand         <= first_cand;
                            pos          <= pos + 2'd1;
                            if (pos == 2'd3) solved <= 1'b1;
                        end else if (pos_miss && has_next) begin
                            cand <= next_cand;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign guess_valid = (state == SCAN_WAIT) || (state == POS_WAIT);
    assign busy        = (state != IDLE) && (state != DONE);

    assign guess_A = guess_q[0];
    assign guess_B = guess_q[1];
    assign guess_C = guess_q[2];
    assign guess_D = guess_q[3];
    assign found_A = found_q[0];
    assign found_B = found_q[1];
    assign found_C = found_q[2];
    assign found_D = found_q[3];

endmodule

// File: tb/tb_bulls_and_cows_solver.sv
// ---------------------------------------------------------------------------
// tb_bulls_and_cows_solver
//
// Drives bulls_and_cows_solver against a behavioural scorer (secret digits,
// an all-zero responder, or an always-four-bulls responder). Expected guess
// sequences and final outcomes are pushed to queues when a solve is started
// and popped as the solver presents guesses and reaches DONE.
// ---------------------------------------------------------------------------
module tb_bulls_and_cows_solver;

`ifdef SOLVER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] resp_in;
    logic       resp_valid;
    logic [2:0] guess_A, guess_B, guess_C, guess_D;
    logic       guess_valid;
    logic       busy;
    logic       solved;
    logic       error;
    logic [2:0] found_A, found_B, found_C, found_D;
    logic [4:0] guess_count;

    bulls_and_cows_solver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .resp_in     (resp_in),
        .resp_valid  (resp_valid),
        .guess_A     (guess_A),
        .guess_B     (guess_B),
        .guess_C     (guess_C),
        .guess_D     (guess_D),
        .guess_valid (guess_valid),
        .busy        (busy),
        .solved      (solved),
        .error       (error),
        .found_A     (found_A),
        .found_B     (found_B),
        .found_C     (found_C),
        .found_D     (found_D),
        .guess_count (guess_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        solved;
        logic        error;
        logic [11:0] found;
        logic [4:0]  count;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] exp_guess_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cap_count = 0;
    int          resp_delay = 0;
    int          resp_mode = 0;
    logic [11:0] secret = 12'd0;
    bit          mon_en = 1'b0;
    bit          chk_guess = 1'b0;

    logic [11:0] gcur;
    logic [11:0] fcur;
    assign gcur = {guess_A, guess_B, guess_C, guess_D};
    assign fcur = {found_A, found_B, found_C, found_D};

    function automatic logic [11:0] g4(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d);
        return {a, b, c, d};
    endfunction

    // mode 0: score against secret; 1: always 0 bulls; 2: always 4 bulls
    function automatic logic [7:0] score(input logic [11:0] g, input logic [11:0] s,
                                         input int mode);
        logic [3:0] b;
        logic [3:0] common;
        logic [3:0] c;
        int         ng, ns;
        b      = 4'd0;
        common = 4'd0;
        if (mode == 1) return 8'h00;
        if (mode == 2) return 8'h20;
        for (int i = 0; i < 4; i++) begin
            if (g[3*i +: 3] == s[3*i +: 3]) b = b + 4'd1;
        end
        for (int v = 0; v < 8; v++) begin
            ng = 0;
            ns = 0;
            for (int i = 0; i < 4; i++) begin
                if (g[3*i +: 3] == 3'(v)) ng++;
                if (s[3*i +: 3] == 3'(v)) ns++;
            end
            common = common + 4'((ng < ns) ? ng : ns);
        end
        c = common - b;
        return {c[3], b[3:2], c[2:0], b[1:0]};
    endfunction

    assign resp_in = score(gcur, secret, resp_mode);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder handshake: tied high when resp_delay is 0, otherwise
    // resp_valid rises after resp_delay cycles of guess_valid, for one cycle.
    initial begin
        int wcnt;
        wcnt       = 0;
        resp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_delay == 0) begin
                resp_valid = 1'b1;
                wcnt       = 0;
            end else if (resp_valid) begin
                resp_valid = 1'b0;
                wcnt       = 0;
            end else if (guess_valid) begin
                wcnt++;
                if (wcnt >= resp_delay) resp_valid = 1'b1;
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: guess stability during a wait, capture counting, guess order.
    initial begin
        bit          prev_wait;
        logic [11:0] prev_guess;
        logic [12:0] eg;
        prev_wait  = 1'b0;
        prev_guess = 12'd0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (prev_wait) begin
                    chk("gv_hold", 64'(guess_valid), 64'(1));
                    chk("guess_stable", 64'(gcur), 64'(prev_guess));
                end
                if (guess_valid && resp_valid) begin
                    cap_count++;
                    if (chk_guess) begin
                        eg = (exp_guess_q.size() > 0) ? {1'b0, exp_guess_q.pop_front()} : 13'h1000;
                        chk("guess_seq", 64'({1'b0, gcur}), 64'(eg));
                    end
                end
                prev_wait = guess_valid && !resp_valid;
            end else begin
                prev_wait = 1'b0;
            end
            prev_guess = gcur;
        end
    end

    task automatic push_scan(input int n);
        for (int d = 0; d < n; d++) exp_guess_q.push_back(g4(3'(d), 3'(d), 3'(d), 3'(d)));
    endtask

    task automatic push_exp(input logic s, input logic e, input logic [11:0] f, input int n);
        exp_t x;
        x.solved = s;
        x.error  = e;
        x.found  = f;
        x.count  = 5'(n);
        exp_q.push_back(x);
    endtask

    task automatic do_start();
        cap_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("lat_busy", 64'(busy), 64'(1));
        chk("lat_gv_low", 64'(guess_valid), 64'(0));
        chk("lat_guess0", 64'(gcur), 64'(0));
        chk("lat_cnt0", 64'({solved, error, guess_count}), 64'(0));
        @(posedge clk);
        #1;
        chk("lat_gv_high", 64'(guess_valid), 64'(1));
    endtask

    task automatic wait_done();
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 64'(busy), 64'(0));
        e = exp_q.pop_front();
        chk("solved", 64'(solved), 64'(e.solved));
        chk("error", 64'(error), 64'(e.error));
        chk("found", 64'(fcur), 64'(e.found));
        chk("guess_count", 64'(guess_count), 64'(e.count));
        chk("captures", 64'(cap_count), 64'(e.count));
        chk("guess_left", 64'(exp_guess_q.size()), 64'(0));
        exp_guess_q.delete();
    endtask

    initial begin
        int reached;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_guess", 64'({gcur, guess_valid, busy, solved, error}), 64'(0));
        chk("rst_found", 64'({fcur, guess_count}), 64'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Secret 3,5,3,0, resp_valid tied high (also high while idle).
        secret     = g4(3'd3, 3'd5, 3'd3, 3'd0);
        resp_mode  = 0;
        resp_delay = 0;
        chk_guess  = 1'b1;
        push_scan(EE ? 6 : 8);
        exp_guess_q.push_back(g4(3'd0, 3'd1, 3'd1, 3'd1));
        exp_guess_q.push_back(g4(3'd3, 3'd1, 3'd1, 3'd1));
        exp_guess_q.push_back(g4(3'd1, 3'd0, 3'd1, 3'd1));
        exp_guess_q.push_back(g4(3'd1, 3'd3, 3'd1, 3'd1));
        exp_guess_q.push_back(g4(3'd1, 3'd5, 3'd1, 3'd1));
        exp_guess_q.push_back(g4(3'd1, 3'd1, 3'd0, 3'd1));
        exp_guess_q.push_back(g4(3'd1, 3'd1, 3'd3, 3'd1));
        exp_guess_q.push_back(g4(3'd1, 3'd1, 3'd1, 3'd0));
        push_exp(1'b1, 1'b0, secret, EE ? 14 : 16);
        do_start();
        wait_done();

        // Secret 7,7,7,7: filler 0.
        secret = g4(3'd7, 3'd7, 3'd7, 3'd7);
        push_scan(8);
        exp_guess_q.push_back(g4(3'd7, 3'd0, 3'd0, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd7, 3'd0, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd7, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd0, 3'd7));
        push_exp(1'b1, 1'b0, secret, 12);
        do_start();
        wait_done();

        // Always zero bulls: inconsistent scan.
        resp_mode = 1;
        push_scan(8);
        push_exp(1'b0, 1'b1, 12'd0, 8);
        do_start();
        wait_done();

        // Always four bulls: 3-bit sum wraps to 0 after the full scan, or
        // with early exit the scan stops at digit 0 and position A fails.
        resp_mode = 2;
        if (EE) begin
            push_scan(1);
            exp_guess_q.push_back(g4(3'd0, 3'd1, 3'd1, 3'd1));
            push_exp(1'b0, 1'b1, 12'd0, 2);
        end else begin
            push_scan(8);
            push_exp(1'b0, 1'b1, 12'd0, 8);
        end
        do_start();
        wait_done();

        // Secret 1,2,6,2 with a 3-cycle response delay and a stray start.
        resp_mode  = 0;
        resp_delay = 3;
        secret     = g4(3'd1, 3'd2, 3'd6, 3'd2);
        push_scan(EE ? 7 : 8);
        exp_guess_q.push_back(g4(3'd1, 3'd0, 3'd0, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd1, 3'd0, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd2, 3'd0, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd1, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd2, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd6, 3'd0));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd0, 3'd1));
        exp_guess_q.push_back(g4(3'd0, 3'd0, 3'd0, 3'd2));
        push_exp(1'b1, 1'b0, secret, EE ? 15 : 16);
        do_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Asynchronous reset while waiting on a position response.
        chk_guess  = 1'b0;
        resp_delay = 5;
        secret     = g4(3'd3, 3'd5, 3'd3, 3'd0);
        do_start();
        reached = 0;
        for (int i = 0; i < 1000 && reached == 0; i++) begin
            @(negedge clk);
            if (guess_valid && guess_count >= 5'd8) reached = 1;
        end
        chk("reach_pos_wait", 64'(reached), 64'(1));
        mon_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_guess", 64'({gcur, guess_valid, busy, solved, error}), 64'(0));
        chk("mid_rst_found", 64'({fcur, guess_count}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", 64'({busy, guess_valid}), 64'(0));
        @(negedge clk);
        mon_en = 1'b1;

        // Restart from IDLE after the reset.
        resp_mode  = 1;
        resp_delay = 0;
        push_exp(1'b0, 1'b1, 12'd0, 8);
        do_start();
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
